id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- ID/EXE pipeline register of the 5-stage MIPS pipeline.
- Captures decoded operands and control from ID and presents them to EXE.
- Its src1_EXE/src2_EXE/ST_src_EXE/dest fields feed the forwarding logic downstream.
- Also detects load-use hazards, which forwarding cannot resolve, and inserts a bubble while signalling ID/IF to hold.

Parameters:
DATA_W, 32, width of operand values and PC
REG_AW, 5, register-address width
CMD_W, 4, width of EXE ALU command (0 = NOP)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
freeze  input  1  global stall (e.g. memory busy); hold all state
flush  input  1  branch-taken flush; load bubble
valid_in  input  1  ID slot holds a real instruction
pc_in  input  DATA_W  PC of ID instruction
val1_in, val2_in, st_val_in  input  DATA_W each  register-file/immediate operands, store data
src1_in, src2_in, st_src_in, dest_in  input  REG_AW each  register addresses
use_src1_in, use_src2_in  input  1 each  instruction actually reads src1/src2
exe_cmd_in  input  CMD_W  ALU command
mem_r_en_in, mem_w_en_in, wb_en_in  input  1 each  stage control
pc_EXE, val1_EXE, val2_EXE, st_val_EXE  output  DATA_W each  registered copies
src1_EXE, src2_EXE, ST_src_EXE, dest_EXE  output  REG_AW each  registered copies
exe_cmd_EXE  output  CMD_W  registered command
MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, valid_EXE  output  1 each  registered control
load_use_stall  output  1  combinational; upstream must hold PC and IF/ID
bubble_count  output  16  bubbles inserted (see optional feature)

Behaviour:
- Reset: clk and rst_n as named. rst_n low asynchronously clears every registered output and bubble_count to 0. An EXE slot in reset is a bubble. Reset mid-stall drops the stalled instruction; upstream re-presents it.
- load_use_stall = valid_in & valid_EXE & MEM_R_EN_EXE & (dest_EXE != 0) & (hit1 | hit2 | hitS), where:
  - hit1 = use_src1_in & (src1_in == dest_EXE)
  - hit2 = use_src2_in & (src2_in == dest_EXE)
  - hitS = mem_w_en_in & (st_src_in == dest_EXE)
- load_use_stall is forced 0 while flush = 1. Register $0 never hazards.
- Per rising edge, priority is flush > freeze > load_use_stall > load:
  - flush: load a bubble.
  - freeze: hold all state.
  - load_use_stall: load a bubble.
  - else: capture all *_in into the matching outputs.
- Bubble: valid_EXE, WB_EN_EXE, MEM_R_EN_EXE, MEM_W_EN_EXE = 0; exe_cmd_EXE = 0; all address fields = 0; data fields and pc = 0.
- Latency is 1 cycle, in to out. No combinational path from *_in to any *_EXE output.
- Stall duration:
  - Without freeze, a load-use stall lasts exactly 1 cycle. After the bubble, MEM_R_EN_EXE = 0, so the held ID instruction loads on the next edge and the forwarding path supplies the load value from the WB stage.
  - If freeze coincides with load_use_stall, freeze wins. The load stays in EXE and load_use_stall stays asserted until freeze drops.
- flush together with freeze: flush wins, and the slot becomes a bubble.
- valid_in = 0 is captured like any instruction (valid_EXE = 0). Upstream must drive its controls to 0 in that case.

Optional Feature:
- Macro: ID_EXE_BUBBLE_CNT_EN.
- Defined: bubble_count increments by 1 on each edge where a bubble is loaded because of load_use_stall. Flush bubbles are not counted. The counter saturates at 16'hFFFF, holds during freeze, and clears on reset.
- Undefined: bubble_count is tied to 16'd0 and no counter flops are built.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle with outputs nonzero -> all outputs 0 immediately, without waiting for a clock edge.
- Normal load: valid_in = 1, src1_in = 3, dest_in = 7, wb_en_in = 1, val1_in = 32'h1234, exe_cmd_in = 4'd2, one edge -> src1_EXE = 3, dest_EXE = 7, WB_EN_EXE = 1, val1_EXE = 32'h1234, exe_cmd_EXE = 2.
- Load-use, src1 path: EXE holds lw with dest_EXE = 5, MEM_R_EN_EXE = 1; ID has use_src1_in = 1, src1_in = 5 -> load_use_stall = 1, next edge gives a bubble (valid_EXE = 0). The following edge captures the ID instruction; bubble_count = 1 when ID_EXE_BUBBLE_CNT_EN is defined.
- $0 and store-data paths:
  - dest_EXE = 0 load with src1_in = 0 -> no stall.
  - dest_EXE = 9 load, mem_w_en_in = 1, st_src_in = 9 -> stall for 1 cycle.
- Priority: flush = 1 with freeze = 1 and stall conditions true -> bubble loaded, load_use_stall = 0, bubble_count unchanged.
- Freeze during hazard: freeze = 1 for 3 cycles with the lw in EXE -> outputs unchanged, load_use_stall = 1 for all 3 cycles. After freeze drops, exactly one bubble is inserted, then the ID instruction loads.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with load-use hazard detection and bubble insertion.
// Optional bubble counter is enabled by defining ID_EXE_BUBBLE_CNT_EN.
module id_exe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CMD_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] val1_in,
  input  logic [DATA_W-1:0] val2_in,
  input  logic [DATA_W-1:0] st_val_in,
  input  logic [REG_AW-1:0] src1_in,
  input  logic [REG_AW-1:0] src2_in,
  input  logic [REG_AW-1:0] st_src_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic              use_src1_in,
  input  logic              use_src2_in,
  input  logic [CMD_W-1:0]  exe_cmd_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic              wb_en_in,
  output logic [DATA_W-1:0] pc_EXE,
  output logic [DATA_W-1:0] val1_EXE,
  output logic [DATA_W-1:0] val2_EXE,
  output logic [DATA_W-1:0] st_val_EXE,
  output logic [REG_AW-1:0] src1_EXE,
  output logic [REG_AW-1:0] src2_EXE,
  output logic [REG_AW-1:0] ST_src_EXE,
  output logic [REG_AW-1:0] dest_EXE,
  output logic [CMD_W-1:0]  exe_cmd_EXE,
  output logic              MEM_R_EN_EXE,
  output logic              MEM_W_EN_EXE,
  output logic              WB_EN_EXE,
  output logic              valid_EXE,
  output logic              load_use_stall,
  output logic [15:0]       bubble_count
);

  logic hit1;
  logic hit2;
  logic hit_s;
  logic load_en;
  logic take_in;

  // A load in EXE whose result the ID instruction needs cannot be forwarded yet.
  assign hit1  = use_src1_in & (src1_in == dest_EXE);
  assign hit2  = use_src2_in & (src2_in == dest_EXE);
  assign hit_s = mem_w_en_in & (st_src_in == dest_EXE);

  assign load_use_stall = ~flush & valid_in & valid_EXE & MEM_R_EN_EXE &
                          (dest_EXE != '0) & (hit1 | hit2 | hit_s);

  // flush overrides freeze; otherwise freeze holds everything.
  assign load_en = flush | ~freeze;
  assign take_in = ~flush & ~load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_EXE       <= '0;
      val1_EXE     <= '0;
      val2_EXE     <= '0;
      st_val_EXE   <= '0;
      src1_EXE     <= '0;
      src2_EXE     <= '0;
      ST_src_EXE   <= '0;
      dest_EXE     <= '0;
      exe_cmd_EXE  <= '0;
      MEM_R_EN_EXE <= 1'b0;
      MEM_W_EN_EXE <= 1'b0;
      WB_EN_EXE    <= 1'b0;
      valid_EXE    <= 1'b0;
    end else if (load_en) begin
      pc_EXE       <= take_in ? pc_in      : '0;
      val1_EXE     <= take_in ? val1_in    : '0;
      val2_EXE     <= take_in ? val2_in    : '0;
      st_val_EXE   <= take_in ? st_val_in  : '0;
      src1_EXE     <= take_in ? src1_in    : '0;
      src2_EXE     <= take_in ? src2_in    : '0;
      ST_src_EXE   <= take_in ? st_src_in  : '0;
      dest_EXE     <= take_in ? dest_in    : '0;
      exe_cmd_EXE  <= take_in ? exe_cmd_in : '0;
      MEM_R_EN_EXE <= take_in & mem_r_en_in;
      MEM_W_EN_EXE <= take_in & mem_w_en_in;
      WB_EN_EXE    <= take_in & wb_en_in;
      valid_EXE    <= take_in & valid_in;
    end
  end

`ifdef ID_EXE_BUBBLE_CNT_EN
  logic        stall_bubble;
  logic [15:0] bubble_cnt_q;

  // Counts only hazard bubbles; flush bubbles and frozen cycles are excluded.
  assign stall_bubble = ~freeze & load_use_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= 16'd0;
    end else if (stall_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bubble_count = bubble_cnt_q;
`else
  assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Self-checking bench for id_exe_stage_reg: directed pipeline scenarios plus
// randomized traffic compared every cycle against a slot-level reference model.
module tb_id_exe_stage_reg;

`ifdef ID_EXE_BUBBLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        freeze, flush, valid_in;
  logic [31:0] pc_in, val1_in, val2_in, st_val_in;
  logic [4:0]  src1_in, src2_in, st_src_in, dest_in;
  logic        use_src1_in, use_src2_in;
  logic [3:0]  exe_cmd_in;
  logic        mem_r_en_in, mem_w_en_in, wb_en_in;
  logic [31:0] pc_EXE, val1_EXE, val2_EXE, st_val_EXE;
  logic [4:0]  src1_EXE, src2_EXE, ST_src_EXE, dest_EXE;
  logic [3:0]  exe_cmd_EXE;
  logic        MEM_R_EN_EXE, MEM_W_EN_EXE, WB_EN_EXE, valid_EXE;
  logic        load_use_stall;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  always #5 clk = ~clk;

  id_exe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val1_in(val1_in), .val2_in(val2_in), .st_val_in(st_val_in),
    .src1_in(src1_in), .src2_in(src2_in), .st_src_in(st_src_in), .dest_in(dest_in),
    .use_src1_in(use_src1_in), .use_src2_in(use_src2_in), .exe_cmd_in(exe_cmd_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in),
    .pc_EXE(pc_EXE), .val1_EXE(val1_EXE), .val2_EXE(val2_EXE), .st_val_EXE(st_val_EXE),
    .src1_EXE(src1_EXE), .src2_EXE(src2_EXE), .ST_src_EXE(ST_src_EXE), .dest_EXE(dest_EXE),
    .exe_cmd_EXE(exe_cmd_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE), .MEM_W_EN_EXE(MEM_W_EN_EXE),
    .WB_EN_EXE(WB_EN_EXE), .valid_EXE(valid_EXE), .load_use_stall(load_use_stall),
    .bubble_count(bubble_count)
  );

  // Reference model: the instruction currently sitting in the EXE slot.
  typedef struct {
    logic [31:0] pc, v1, v2, sv;
    logic [4:0]  s1, s2, ss, d;
    logic [3:0]  cmd;
    logic        mr, mw, wb, vld;
  } slot_t;

  slot_t       m;
  int unsigned m_cnt;

  function automatic slot_t empty_slot();
    slot_t s;
    s.pc = 32'd0; s.v1 = 32'd0; s.v2 = 32'd0; s.sv = 32'd0;
    s.s1 = 5'd0; s.s2 = 5'd0; s.ss = 5'd0; s.d = 5'd0; s.cmd = 4'd0;
    s.mr = 1'b0; s.mw = 1'b0; s.wb = 1'b0; s.vld = 1'b0;
    return s;
  endfunction

  function automatic slot_t id_slot();
    slot_t s;
    s.pc = pc_in; s.v1 = val1_in; s.v2 = val2_in; s.sv = st_val_in;
    s.s1 = src1_in; s.s2 = src2_in; s.ss = st_src_in; s.d = dest_in; s.cmd = exe_cmd_in;
    s.mr = mem_r_en_in; s.mw = mem_w_en_in; s.wb = wb_en_in; s.vld = valid_in;
    return s;
  endfunction

  // ID needs a register that a load in EXE has not produced yet.
  function automatic bit model_stall();
    bit needs;
    if (flush || !valid_in || !m.vld || !m.mr || m.d == 5'd0) return 1'b0;
    needs = (use_src1_in && src1_in == m.d) || (use_src2_in && src2_in == m.d) ||
            (mem_w_en_in && st_src_in == m.d);
    return needs;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     = empty_slot();
      m_cnt = 0;
    end else if (flush) begin
      m = empty_slot();
    end else if (!freeze) begin
      if (model_stall()) begin
        m = empty_slot();
        if (CNT_EN && m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
      end else begin
        m = id_slot();
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_EXE", 64'(pc_EXE), 64'(m.pc));
    chk("val1_EXE", 64'(val1_EXE), 64'(m.v1));
    chk("val2_EXE", 64'(val2_EXE), 64'(m.v2));
    chk("st_val_EXE", 64'(st_val_EXE), 64'(m.sv));
    chk("src1_EXE", 64'(src1_EXE), 64'(m.s1));
    chk("src2_EXE", 64'(src2_EXE), 64'(m.s2));
    chk("ST_src_EXE", 64'(ST_src_EXE), 64'(m.ss));
    chk("dest_EXE", 64'(dest_EXE), 64'(m.d));
    chk("exe_cmd_EXE", 64'(exe_cmd_EXE), 64'(m.cmd));
    chk("MEM_R_EN_EXE", 64'(MEM_R_EN_EXE), 64'(m.mr));
    chk("MEM_W_EN_EXE", 64'(MEM_W_EN_EXE), 64'(m.mw));
    chk("WB_EN_EXE", 64'(WB_EN_EXE), 64'(m.wb));
    chk("valid_EXE", 64'(valid_EXE), 64'(m.vld));
    chk("load_use_stall", 64'(load_use_stall), 64'(model_stall()));
    chk("bubble_count", 64'(bubble_count), 64'(m_cnt));
  endtask

  // Compare process: inputs change just after posedge, so negedge sees settled values.
  always @(negedge clk) begin
    if (run_cmp && rst_n) check_all();
  end

  task automatic idle_in();
    freeze = 0; flush = 0; valid_in = 0;
    pc_in = 0; val1_in = 0; val2_in = 0; st_val_in = 0;
    src1_in = 0; src2_in = 0; st_src_in = 0; dest_in = 0;
    use_src1_in = 0; use_src2_in = 0; exe_cmd_in = 0;
    mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lw(input logic [4:0] d);
    idle_in();
    valid_in = 1; dest_in = d; mem_r_en_in = 1; wb_en_in = 1; exe_cmd_in = 4'd1;
    pc_in = 32'h100;
  endtask

  task automatic rand_in();
    freeze = ($urandom_range(0, 99) < 15);
    flush  = ($urandom_range(0, 99) < 8);
    valid_in = ($urandom_range(0, 99) < 85);
    pc_in = $urandom; val1_in = $urandom; val2_in = $urandom; st_val_in = $urandom;
    src1_in = 5'($urandom_range(0, 3)); src2_in = 5'($urandom_range(0, 3));
    st_src_in = 5'($urandom_range(0, 3)); dest_in = 5'($urandom_range(0, 3));
    use_src1_in = 1'($urandom); use_src2_in = 1'($urandom);
    if (valid_in) begin
      exe_cmd_in  = 4'($urandom);
      mem_r_en_in = ($urandom_range(0, 99) < 40);
      mem_w_en_in = !mem_r_en_in && 1'($urandom);
      wb_en_in    = 1'($urandom);
    end else begin
      exe_cmd_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; wb_en_in = 0;
      use_src1_in = 0; use_src2_in = 0;
    end
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    #12;
    chk("reset valid_EXE", 64'(valid_EXE), 64'd0);
    chk("reset bubble_count", 64'(bubble_count), 64'd0);
    rst_n = 1;
    run_cmp = 1'b1;

    // Normal load
    step();
    valid_in = 1; src1_in = 5'd3; use_src1_in = 1; dest_in = 5'd7; wb_en_in = 1;
    val1_in = 32'h1234; exe_cmd_in = 4'd2;
    step();
    chk("load src1_EXE", 64'(src1_EXE), 64'd3);
    chk("load dest_EXE", 64'(dest_EXE), 64'd7);
    chk("load WB_EN_EXE", 64'(WB_EN_EXE), 64'd1);
    chk("load val1_EXE", 64'(val1_EXE), 64'h1234);
    chk("load exe_cmd_EXE", 64'(exe_cmd_EXE), 64'd2);

    // Load-use on src1
    drive_lw(5'd5);
    step();
    idle_in(); valid_in = 1; use_src1_in = 1; src1_in = 5'd5; dest_in = 5'd6;
    wb_en_in = 1; exe_cmd_in = 4'd3;
    #1 chk("lu src1 stall", 64'(load_use_stall), 64'd1);
    step();
    chk("lu bubble valid_EXE", 64'(valid_EXE), 64'd0);
    chk("lu bubble stall low", 64'(load_use_stall), 64'd0);
    step();
    chk("lu capture valid_EXE", 64'(valid_EXE), 64'd1);
    chk("lu capture src1_EXE", 64'(src1_EXE), 64'd5);
    chk("lu bubble_count 1", 64'(bubble_count), CNT_EN ? 64'd1 : 64'd0);

    // $0 never hazards
    drive_lw(5'd0);
    step();
    idle_in(); valid_in = 1; use_src1_in = 1; src1_in = 5'd0;
    #1 chk("r0 no stall", 64'(load_use_stall), 64'd0);

    // Store-data path
    drive_lw(5'd9);
    step();
    idle_in(); valid_in = 1; mem_w_en_in = 1; st_src_in = 5'd9;
    #1 chk("store stall", 64'(load_use_stall), 64'd1);
    step();
    chk("store bubble", 64'(valid_EXE), 64'd0);
    step();
    chk("store capture", 64'(MEM_W_EN_EXE), 64'd1);

    // flush + freeze + hazard
    drive_lw(5'd5);
    step();
    idle_in(); valid_in = 1; use_src2_in = 1; src2_in = 5'd5; flush = 1; freeze = 1;
    #1 chk("prio stall masked", 64'(load_use_stall), 64'd0);
    step();
    chk("prio bubble", 64'(valid_EXE), 64'd0);
    chk("prio count", 64'(bubble_count), CNT_EN ? 64'd2 : 64'd0);

    // Freeze during hazard
    drive_lw(5'd4);
    step();
    idle_in(); valid_in = 1; use_src1_in = 1; src1_in = 5'd4; dest_in = 5'd8; freeze = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("frz stall", 64'(load_use_stall), 64'd1);
      step();
      chk("frz dest held", 64'(dest_EXE), 64'd4);
      chk("frz mr held", 64'(MEM_R_EN_EXE), 64'd1);
    end
    freeze = 0;
    #1 chk("frz release stall", 64'(load_use_stall), 64'd1);
    step();
    chk("frz bubble", 64'(valid_EXE), 64'd0);
    step();
    chk("frz capture", 64'(dest_EXE), 64'd8);
    chk("frz count", 64'(bubble_count), CNT_EN ? 64'd3 : 64'd0);

    // Randomized traffic with one asynchronous mid-cycle reset
    for (int c = 0; c < 3000; c++) begin
      step();
      rand_in();
      if (c == 1500) begin
        #1 rst_n = 0;
        #1;
        chk("async rst valid", 64'(valid_EXE), 64'd0);
        chk("async rst pc", 64'(pc_EXE), 64'd0);
        chk("async rst dest", 64'(dest_EXE), 64'd0);
        chk("async rst count", 64'(bubble_count), 64'd0);
        rst_n = 1;
      end
    end

    run_cmp = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
